// File: rtl/window_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// window_scan_ctrl_pkg
// Shared types and helpers for the 3x3 window scan controller.
//   state_t  : controller FSM states (IDLE, RUN, DONE)
//   STRIDE_* : decoded stride values held in the latched stride register
//   out_dim  : number of output-map positions along one image dimension
// -----------------------------------------------------------------------------
package window_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] STRIDE_1 = 2'd1;
    localparam logic [1:0] STRIDE_2 = 2'd2;

    // Windows along a dimension of img_dim pixels for a 3-tap kernel.
    function automatic int unsigned out_dim(input int unsigned img_dim,
                                            input int unsigned stride);
        return (img_dim - 3) / stride + 1;
    endfunction

endpackage

// File: rtl/window_scan_ctrl_scan_counter.sv
// -----------------------------------------------------------------------------
// window_scan_ctrl_scan_counter
// Raster position counter (column inner, row outer) with stride phase bits.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clear_i        : synchronous clear of position and phase
//   advance_i      : step one raster position
//   stride2_i      : 1 = stride 2 alignment, 0 = stride 1
//   col_max_i      : last column index (wrap limit)
//   row_max_i      : last row index (wrap limit)
//   col_o, row_o   : current position
//   hit_o          : position is >= OFFSET on both axes and stride aligned
// -----------------------------------------------------------------------------
module window_scan_ctrl_scan_counter #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned OFFSET    = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 advance_i,
    input  logic                 stride2_i,
    input  logic [CNT_WIDTH-1:0] col_max_i,
    input  logic [CNT_WIDTH-1:0] row_max_i,
    output logic [CNT_WIDTH-1:0] col_o,
    output logic [CNT_WIDTH-1:0] row_o,
    output logic                 hit_o
);

    localparam logic [CNT_WIDTH-1:0] OFF = CNT_WIDTH'(OFFSET);

    logic [CNT_WIDTH-1:0] col_q, col_d;
    logic [CNT_WIDTH-1:0] row_q, row_d;
    logic                 cph_q, cph_d;
    logic                 rph_q, rph_d;
    logic                 col_ok, row_ok;

    // Phase bit holds (pos - OFFSET) mod 2: forced to 0 up to OFFSET, then
    // toggles on every step, so no divider is needed for alignment.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        cph_d = cph_q;
        rph_d = rph_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
            cph_d = 1'b0;
            rph_d = 1'b0;
        end else if (advance_i) begin
            if (col_q == col_max_i) begin
                col_d = '0;
                cph_d = 1'b0;
                row_d = (row_q == row_max_i) ? '0 : row_q + 1'b1;
                rph_d = (row_d <= OFF) ? 1'b0 : ~rph_q;
            end else begin
                col_d = col_q + 1'b1;
                cph_d = (col_d <= OFF) ? 1'b0 : ~cph_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            col_q <= '0;
            row_q <= '0;
            cph_q <= 1'b0;
            rph_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            cph_q <= cph_d;
            rph_q <= rph_d;
        end
    end

    generate
        if (OFFSET == 0) begin : g_no_offset
            assign col_ok = 1'b1;
            assign row_ok = 1'b1;
        end else begin : g_offset
            assign col_ok = (col_q >= OFF);
            assign row_ok = (row_q >= OFF);
        end
    endgenerate

    assign col_o = col_q;
    assign row_o = row_q;
    assign hit_o = col_ok & row_ok & (~stride2_i | (~cph_q & ~rph_q));

endmodule

// File: rtl/window_scan_ctrl.sv
// -----------------------------------------------------------------------------
// window_scan_ctrl
// Sequencing controller for a 3x3 window generator fed by a raster stream.
//   clk, reset            : clock, asynchronous active-high reset
//   start, cfg_stride     : frame start pulse (IDLE only), stride latched on it
//   in_valid / in_ready   : upstream pixel handshake
//   lb_shift_en           : generator shift enable (accepted pixel)
//   win_valid / win_ready : downstream window handshake
//   win_row, win_col      : output-map coordinates of the presented window
//   last_win              : final window of the frame
//   busy, done            : frame in progress / one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module window_scan_ctrl
    import window_scan_ctrl_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 30,
    parameter int unsigned IMG_HEIGHT = 30,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           cfg_stride,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 lb_shift_en,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [CNT_WIDTH-1:0] win_row,
    output logic [CNT_WIDTH-1:0] win_col,
    output logic                 last_win,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_WIDTH-1:0] IN_COL_MAX  = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] IN_ROW_MAX  = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] OUT_COL_S1  = CNT_WIDTH'(out_dim(IMG_WIDTH, 1) - 1);
    localparam logic [CNT_WIDTH-1:0] OUT_COL_S2  = CNT_WIDTH'(out_dim(IMG_WIDTH, 2) - 1);
    localparam logic [CNT_WIDTH-1:0] OUT_ROW_S1  = CNT_WIDTH'(out_dim(IMG_HEIGHT, 1) - 1);
    localparam logic [CNT_WIDTH-1:0] OUT_ROW_S2  = CNT_WIDTH'(out_dim(IMG_HEIGHT, 2) - 1);

    state_t               state_q;
    logic [1:0]           stride_q;
    logic                 busy_q, done_q;

    logic                 stride2, clear, run, wh, accept, win_xfer;
    logic                 in_hit, out_hit;
    logic [CNT_WIDTH-1:0] in_col, in_row;
    logic [CNT_WIDTH-1:0] out_col_max, out_row_max;

    assign stride2     = (stride_q == STRIDE_2);
    assign clear       = (state_q == IDLE) & start;
    assign run         = (state_q == RUN);
    assign out_col_max = stride2 ? OUT_COL_S2 : OUT_COL_S1;
    assign out_row_max = stride2 ? OUT_ROW_S2 : OUT_ROW_S1;

    window_scan_ctrl_scan_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .OFFSET    (2)
    ) u_in_cnt (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (clear),
        .advance_i (accept),
        .stride2_i (stride2),
        .col_max_i (IN_COL_MAX),
        .row_max_i (IN_ROW_MAX),
        .col_o     (in_col),
        .row_o     (in_row),
        .hit_o     (in_hit)
    );

    window_scan_ctrl_scan_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .OFFSET    (0)
    ) u_out_cnt (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (clear),
        .advance_i (win_xfer),
        .stride2_i (1'b0),
        .col_max_i (out_col_max),
        .row_max_i (out_row_max),
        .col_o     (win_col),
        .row_o     (win_row),
        .hit_o     (out_hit)
    );

    // win_valid is independent of in_ready, so the handshake has no loop.
    assign wh          = run & in_hit;
    assign win_valid   = in_valid & wh;
    assign in_ready    = run & (~wh | win_ready);
    assign accept      = in_valid & in_ready;
    assign lb_shift_en = accept;
    assign win_xfer    = win_valid & win_ready;

    // The output raster runs at offset 0 / stride 1, so out_hit is always set.
    assign last_win = wh & out_hit & (win_row == out_row_max) & (win_col == out_col_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            stride_q <= STRIDE_1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        stride_q <= (cfg_stride == STRIDE_2) ? STRIDE_2 : STRIDE_1;
                    end
                end
                RUN: begin
                    if (accept && (in_col == IN_COL_MAX) && (in_row == IN_ROW_MAX)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_window_scan_ctrl
// Self-checking bench for window_scan_ctrl on a 5x5 image. Expected windows
// (accept index, output row/col, last flag) are queued at frame start and
// popped on every window transfer.
// -----------------------------------------------------------------------------
module tb_window_scan_ctrl;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    cfg_stride;
    logic          in_valid;
    logic          in_ready;
    logic          lb_shift_en;
    logic          win_valid;
    logic          win_ready;
    logic [CW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          last_win;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    window_scan_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_stride  (cfg_stride),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lb_shift_en (lb_shift_en),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_row     (win_row),
        .win_col     (win_col),
        .last_win    (last_win),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        int idx;
        int row;
        int col;
        bit last;
    } exp_t;

    typedef struct {
        logic [1:0] cfg;
        int         s;
        int         vpct;
        int         rpct;
        int         exp_wins;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];

    int checks    = 0;
    int failures  = 0;
    int acc_cnt   = 0;
    int win_cnt   = 0;
    int done_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (win_valid && !in_valid)
            chk("win_valid_without_in_valid", 1, 0);
        if (win_valid && win_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_window", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("win_accept_idx", acc_cnt, e.idx);
                chk("win_row", win_row, e.row);
                chk("win_col", win_col, e.col);
                chk("last_win", last_win, e.last);
                win_cnt++;
            end
        end
        if (lb_shift_en) acc_cnt++;
        if (done) begin
            done_cnt++;
            chk("busy_low_with_done", busy, 0);
        end
    end

    task automatic load_sb(input int s);
        exp_t e;
        sb.delete();
        for (int r = 2; r < H; r += s)
            for (int c = 2; c < W; c += s)
                sb.push_back('{r * W + c, (r - 2) / s, (c - 2) / s, 1'b0});
        e = sb[sb.size() - 1];
        e.last = 1'b1;
        sb[sb.size() - 1] = e;
    endtask

    task automatic begin_frame(input logic [1:0] cfg, input int s);
        load_sb(s);
        acc_cnt  = 0;
        win_cnt  = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        start      = 1'b1;
        cfg_stride = cfg;
        chk("busy_before_start_sampled", busy, 0);
        @(posedge clk); #1;
        start      = 1'b0;
        cfg_stride = 2'd0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic finish_frame(input string tag, input int vpct, input int rpct, input int exp_wins);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 400) begin
            in_valid  = ($urandom_range(99) < vpct);
            win_ready = ($urandom_range(99) < rpct);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b1;
        win_ready = 1'b1;
        chk({tag, "_idle_in_ready"}, in_ready, 0);
        chk({tag, "_busy_after_done"}, busy, 0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_windows"}, win_cnt, exp_wins);
        chk({tag, "_accepts"}, acc_cnt, W * H);
        chk({tag, "_sb_left"}, sb.size(), 0);
        in_valid = 1'b0;
    endtask

    task automatic wait_accepts(input int n);
        int cyc = 0;
        while (acc_cnt < n && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("wait_accepts_reached", acc_cnt, n);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        cfg_stride = 2'd0;
        in_valid   = 1'b0;
        win_ready  = 1'b0;

        tbl[0] = '{2'd1, 1, 100, 100, 9};
        tbl[1] = '{2'd2, 2, 100, 100, 4};
        tbl[2] = '{2'd3, 1, 100, 100, 9};
        tbl[3] = '{2'd1, 1,  60, 100, 9};
        tbl[4] = '{2'd0, 1,  70,  70, 9};
        tbl[5] = '{2'd2, 2,  60,  50, 4};

        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_lb_shift_en", lb_shift_en, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_last_win", last_win, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);

        @(posedge clk); #1;
        reset     = 1'b0;
        in_valid  = 1'b1;
        win_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_in_ready", in_ready, 0);
            chk("idle_lb_shift_en", lb_shift_en, 0);
            chk("idle_busy", busy, 0);
        end
        chk("idle_no_accepts", acc_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            begin_frame(tbl[i].cfg, tbl[i].s);
            finish_frame($sformatf("vec%0d", i), tbl[i].vpct, tbl[i].rpct, tbl[i].exp_wins);
        end

        // Back-pressure while the window at input (3,2) is presented.
        begin_frame(2'd1, 1);
        in_valid  = 1'b1;
        win_ready = 1'b1;
        wait_accepts(3 * W + 2);
        win_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_lb_shift_en", lb_shift_en, 0);
            chk("stall_win_valid", win_valid, 1);
            chk("stall_win_row", win_row, 1);
            chk("stall_win_col", win_col, 0);
            chk("stall_last_win", last_win, 0);
            chk("stall_accepts_frozen", acc_cnt, 3 * W + 2);
        end
        @(posedge clk); #1;
        finish_frame("stall", 100, 100, 9);

        // start (with a stride-2 request) pulsed mid-frame must be ignored.
        begin_frame(2'd1, 1);
        in_valid  = 1'b1;
        win_ready = 1'b1;
        wait_accepts(8);
        start      = 1'b1;
        cfg_stride = 2'd2;
        @(posedge clk); #1;
        start      = 1'b0;
        cfg_stride = 2'd0;
        chk("mid_start_busy", busy, 1);
        finish_frame("mid_start", 100, 100, 9);

        // Reset while presenting input (3,1), then a clean full frame.
        begin_frame(2'd1, 1);
        in_valid  = 1'b1;
        win_ready = 1'b1;
        wait_accepts(3 * W + 1);
        chk("pre_reset_win_row", win_row, 1);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_lb_shift_en", lb_shift_en, 0);
        chk("midrst_win_valid", win_valid, 0);
        chk("midrst_last_win", last_win, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_win_row", win_row, 0);
        chk("midrst_win_col", win_col, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        begin_frame(2'd1, 1);
        finish_frame("after_reset", 100, 100, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
